// File: rtl/mmu_bus_master.sv
// CPU-side initiator of the MMU request/response protocol; optionally splits word accesses into two bytes.
// Optional MMU wait timeout is compiled in with `define MMU_BUS_TIMEOUT_EN.
module mmu_bus_master #(
    parameter int unsigned SPLIT_WORDS    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic [1:0]  cpu_req_op,
    input  logic        cpu_req_size,
    input  logic [15:0] cpu_req_addr,
    input  logic [15:0] cpu_req_wdata,
    output logic        cpu_resp_valid,
    output logic [15:0] cpu_resp_rdata,
    output logic        cpu_resp_err,
    output logic [1:0]  req_op,
    output logic        req_size,
    output logic [15:0] req_addr,
    output logic [15:0] req_wdata,
    input  logic        resp_valid,
    input  logic [15:0] resp_rdata
);

    localparam logic [1:0] OP_IDLE   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic       SIZE_BYTE = 1'b0;
    localparam logic       SIZE_WORD = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_XFER_LO, S_XFER_HI, S_RESP} state_t;

    state_t      r_state, w_state;
    logic [1:0]  r_req_op, w_req_op;
    logic        r_req_size, w_req_size;
    logic [15:0] r_req_addr, w_req_addr;
    logic [15:0] r_req_wdata, w_req_wdata;
    logic        r_resp_valid, w_resp_valid;
    logic [15:0] r_resp_rdata, w_resp_rdata;
    logic        r_resp_err, w_resp_err;
    logic        r_ready, w_ready;
    logic        r_is_write, w_is_write;
    logic        r_split, w_split;
    logic [7:0]  r_hi_wdata, w_hi_wdata;
    logic [7:0]  r_lo_rdata, w_lo_rdata;
    logic        w_timeout;

`ifdef MMU_BUS_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wait;

    // Wait counter restarts whenever the state changes, i.e. on entry to each XFER phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= 16'd0;
        end else if (w_state != r_state) begin
            r_wait <= 16'd0;
        end else begin
            r_wait <= r_wait + 16'd1;
        end
    end

    assign w_timeout = !resp_valid && (r_wait == WAIT_LIMIT);
`else
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    // Next-state and next-output logic for every registered output.
    always_comb begin
        w_state      = r_state;
        w_req_op     = r_req_op;
        w_req_size   = r_req_size;
        w_req_addr   = r_req_addr;
        w_req_wdata  = r_req_wdata;
        w_resp_valid = 1'b0;
        w_resp_rdata = 16'h0000;
        w_resp_err   = 1'b0;
        w_is_write   = r_is_write;
        w_split      = r_split;
        w_hi_wdata   = r_hi_wdata;
        w_lo_rdata   = r_lo_rdata;

        case (r_state)
            S_IDLE: begin
                if (cpu_req_valid && (cpu_req_op != OP_IDLE)) begin
                    w_state     = S_XFER_LO;
                    w_is_write  = (cpu_req_op == OP_WRITE);
                    w_split     = (SPLIT_WORDS != 0) && (cpu_req_size == SIZE_WORD);
                    w_req_op    = cpu_req_op;
                    w_req_size  = w_split ? SIZE_BYTE : cpu_req_size;
                    w_req_addr  = cpu_req_addr;
                    w_req_wdata = w_split ? {8'h00, cpu_req_wdata[7:0]} : cpu_req_wdata;
                    w_hi_wdata  = cpu_req_wdata[15:8];
                end
            end
            S_XFER_LO: begin
                if (resp_valid) begin
                    if (r_split) begin
                        w_state     = S_XFER_HI;
                        w_req_addr  = r_req_addr + 16'd1;
                        w_req_wdata = {8'h00, r_hi_wdata};
                        w_lo_rdata  = resp_rdata[7:0];
                    end else begin
                        w_state      = S_RESP;
                        w_req_op     = OP_IDLE;
                        w_resp_valid = 1'b1;
                        if (!r_is_write) begin
                            w_resp_rdata = (r_req_size == SIZE_WORD) ? resp_rdata
                                                                     : {8'h00, resp_rdata[7:0]};
                        end
                    end
                end else if (w_timeout) begin
                    w_state      = S_RESP;
                    w_req_op     = OP_IDLE;
                    w_resp_valid = 1'b1;
                    w_resp_err   = 1'b1;
                    w_resp_rdata = 16'hFFFF;
                end
            end
            S_XFER_HI: begin
                if (resp_valid) begin
                    w_state      = S_RESP;
                    w_req_op     = OP_IDLE;
                    w_resp_valid = 1'b1;
                    if (!r_is_write) begin
                        w_resp_rdata = {resp_rdata[7:0], r_lo_rdata};
                    end
                end else if (w_timeout) begin
                    w_state      = S_RESP;
                    w_req_op     = OP_IDLE;
                    w_resp_valid = 1'b1;
                    w_resp_err   = 1'b1;
                    w_resp_rdata = 16'hFFFF;
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state  = S_IDLE;
                w_req_op = OP_IDLE;
            end
        endcase

        w_ready = (w_state == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_op     <= OP_IDLE;
            r_req_size   <= SIZE_BYTE;
            r_req_addr   <= 16'h0000;
            r_req_wdata  <= 16'h0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 16'h0000;
            r_resp_err   <= 1'b0;
            r_ready      <= 1'b1;
            r_is_write   <= 1'b0;
            r_split      <= 1'b0;
            r_hi_wdata   <= 8'h00;
            r_lo_rdata   <= 8'h00;
        end else begin
            r_state      <= w_state;
            r_req_op     <= w_req_op;
            r_req_size   <= w_req_size;
            r_req_addr   <= w_req_addr;
            r_req_wdata  <= w_req_wdata;
            r_resp_valid <= w_resp_valid;
            r_resp_rdata <= w_resp_rdata;
            r_resp_err   <= w_resp_err;
            r_ready      <= w_ready;
            r_is_write   <= w_is_write;
            r_split      <= w_split;
            r_hi_wdata   <= w_hi_wdata;
            r_lo_rdata   <= w_lo_rdata;
        end
    end

    assign cpu_req_ready  = r_ready;
    assign cpu_resp_valid = r_resp_valid;
    assign cpu_resp_rdata = r_resp_rdata;
    assign cpu_resp_err   = r_resp_err;
    assign req_op         = r_req_op;
    assign req_size       = r_req_size;
    assign req_addr       = r_req_addr;
    assign req_wdata      = r_req_wdata;

endmodule

// File: tb/tb_mmu_bus_master.sv
// Directed bench for mmu_bus_master: split-word instance (a_*) and passthrough instance (b_*).
module tb_mmu_bus_master;

    logic clk;
    logic reset;

    logic        a_cpu_req_valid, a_cpu_req_ready, a_cpu_req_size, a_cpu_resp_valid, a_cpu_resp_err;
    logic [1:0]  a_cpu_req_op, a_req_op;
    logic [15:0] a_cpu_req_addr, a_cpu_req_wdata, a_cpu_resp_rdata, a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_req_size, a_resp_valid;

    logic        b_cpu_req_valid, b_cpu_req_ready, b_cpu_req_size, b_cpu_resp_valid, b_cpu_resp_err;
    logic [1:0]  b_cpu_req_op, b_req_op;
    logic [15:0] b_cpu_req_addr, b_cpu_req_wdata, b_cpu_resp_rdata, b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_req_size, b_resp_valid;

    int checks = 0;
    int errors = 0;

    mmu_bus_master #(.SPLIT_WORDS(1), .TIMEOUT_CYCLES(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .cpu_req_valid(a_cpu_req_valid), .cpu_req_ready(a_cpu_req_ready),
        .cpu_req_op(a_cpu_req_op), .cpu_req_size(a_cpu_req_size),
        .cpu_req_addr(a_cpu_req_addr), .cpu_req_wdata(a_cpu_req_wdata),
        .cpu_resp_valid(a_cpu_resp_valid), .cpu_resp_rdata(a_cpu_resp_rdata),
        .cpu_resp_err(a_cpu_resp_err),
        .req_op(a_req_op), .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata)
    );

    mmu_bus_master #(.SPLIT_WORDS(0), .TIMEOUT_CYCLES(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .cpu_req_valid(b_cpu_req_valid), .cpu_req_ready(b_cpu_req_ready),
        .cpu_req_op(b_cpu_req_op), .cpu_req_size(b_cpu_req_size),
        .cpu_req_addr(b_cpu_req_addr), .cpu_req_wdata(b_cpu_req_wdata),
        .cpu_resp_valid(b_cpu_resp_valid), .cpu_resp_rdata(b_cpu_resp_rdata),
        .cpu_resp_err(b_cpu_resp_err),
        .req_op(b_req_op), .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_request(input logic [1:0] op, input logic size,
                             input logic [15:0] addr, input logic [15:0] wdata);
        a_cpu_req_valid = 1'b1;
        a_cpu_req_op    = op;
        a_cpu_req_size  = size;
        a_cpu_req_addr  = addr;
        a_cpu_req_wdata = wdata;
    endtask

    initial begin
        reset = 1'b1;
        a_cpu_req_valid = 0; a_cpu_req_op = 0; a_cpu_req_size = 0; a_cpu_req_addr = 0; a_cpu_req_wdata = 0;
        a_resp_valid = 0; a_resp_rdata = 0;
        b_cpu_req_valid = 0; b_cpu_req_op = 0; b_cpu_req_size = 0; b_cpu_req_addr = 0; b_cpu_req_wdata = 0;
        b_resp_valid = 0; b_resp_rdata = 0;
        tick();
        tick();
        chk("rst_ready", 16'(a_cpu_req_ready), 16'h1);
        chk("rst_req_op", 16'(a_req_op), 16'h0);
        chk("rst_req_addr", a_req_addr, 16'h0000);
        chk("rst_resp_valid", 16'(a_cpu_resp_valid), 16'h0);
        reset = 1'b0;
        tick();

        // Valid with op=IDLE must be ignored.
        a_request(2'd0, 1'b0, 16'h1111, 16'h0);
        tick();
        a_cpu_req_valid = 1'b0;
        chk("idle_op_req_op", 16'(a_req_op), 16'h0);
        chk("idle_op_ready", 16'(a_cpu_req_ready), 16'h1);
        tick();
        chk("idle_op_no_resp", 16'(a_cpu_resp_valid), 16'h0);

        // Byte read 0xC000 with two MMU wait cycles.
        a_request(2'd1, 1'b0, 16'hC000, 16'h0);
        tick();
        a_cpu_req_valid = 1'b0;
        chk("br_req_op", 16'(a_req_op), 16'h1);
        chk("br_addr0", a_req_addr, 16'hC000);
        chk("br_size0", 16'(a_req_size), 16'h0);
        chk("br_ready_busy", 16'(a_cpu_req_ready), 16'h0);
        tick();
        chk("br_addr1", a_req_addr, 16'hC000);
        tick();
        chk("br_addr2", a_req_addr, 16'hC000);
        chk("br_size2", 16'(a_req_size), 16'h0);
        a_resp_valid = 1'b1; a_resp_rdata = 16'h12AB;
        tick();
        a_resp_valid = 1'b0;
        chk("br_resp_valid", 16'(a_cpu_resp_valid), 16'h1);
        chk("br_rdata", a_cpu_resp_rdata, 16'h00AB);
        chk("br_err", 16'(a_cpu_resp_err), 16'h0);
        chk("br_req_idle", 16'(a_req_op), 16'h0);
        chk("br_ready_resp", 16'(a_cpu_req_ready), 16'h0);
        tick();
        chk("br_pulse_end", 16'(a_cpu_resp_valid), 16'h0);
        chk("br_ready_after", 16'(a_cpu_req_ready), 16'h1);

        // Split word write 0xD000 <- 0xBEEF, zero-wait MMU.
        a_request(2'd2, 1'b1, 16'hD000, 16'hBEEF);
        tick();
        a_cpu_req_valid = 1'b0;
        chk("ww_lo_op", 16'(a_req_op), 16'h2);
        chk("ww_lo_size", 16'(a_req_size), 16'h0);
        chk("ww_lo_addr", a_req_addr, 16'hD000);
        chk("ww_lo_data", 16'(a_req_wdata[7:0]), 16'h00EF);
        a_resp_valid = 1'b1; a_resp_rdata = 16'h5A5A;
        tick();
        chk("ww_hi_op", 16'(a_req_op), 16'h2);
        chk("ww_hi_addr", a_req_addr, 16'hD001);
        chk("ww_hi_data", 16'(a_req_wdata[7:0]), 16'h00BE);
        chk("ww_hi_no_resp", 16'(a_cpu_resp_valid), 16'h0);
        tick();
        a_resp_valid = 1'b0;
        chk("ww_resp_valid", 16'(a_cpu_resp_valid), 16'h1);
        chk("ww_rdata", a_cpu_resp_rdata, 16'h0000);
        chk("ww_req_idle", 16'(a_req_op), 16'h0);
        tick();

        // Split word read at 0xFFFF wraps the HI address to 0x0000.
        a_request(2'd1, 1'b1, 16'hFFFF, 16'h0);
        tick();
        a_cpu_req_valid = 1'b0;
        chk("wr_lo_addr", a_req_addr, 16'hFFFF);
        a_resp_valid = 1'b1; a_resp_rdata = 16'hAA34;
        tick();
        chk("wr_hi_addr", a_req_addr, 16'h0000);
        chk("wr_hi_op", 16'(a_req_op), 16'h1);
        a_resp_rdata = 16'h5512;
        tick();
        a_resp_valid = 1'b0;
        chk("wr_resp_valid", 16'(a_cpu_resp_valid), 16'h1);
        chk("wr_rdata", a_cpu_resp_rdata, 16'h1234);
        tick();

        // Passthrough instance: single WORD transaction.
        b_cpu_req_valid = 1'b1; b_cpu_req_op = 2'd1; b_cpu_req_size = 1'b1; b_cpu_req_addr = 16'h8000;
        tick();
        b_cpu_req_valid = 1'b0;
        chk("pt_size", 16'(b_req_size), 16'h1);
        chk("pt_addr", b_req_addr, 16'h8000);
        b_resp_valid = 1'b1; b_resp_rdata = 16'hCAFE;
        tick();
        b_resp_valid = 1'b0;
        chk("pt_resp_valid", 16'(b_cpu_resp_valid), 16'h1);
        chk("pt_rdata", b_cpu_resp_rdata, 16'hCAFE);
        chk("pt_req_idle", 16'(b_req_op), 16'h0);
        tick();

`ifdef MMU_BUS_TIMEOUT_EN
        // No MMU response: abort after four wait cycles.
        a_request(2'd1, 1'b0, 16'h1234, 16'h0);
        tick();
        a_cpu_req_valid = 1'b0;
        chk("to_wait0_op", 16'(a_req_op), 16'h1);
        tick(); tick(); tick();
        chk("to_wait3_op", 16'(a_req_op), 16'h1);
        chk("to_wait3_no_resp", 16'(a_cpu_resp_valid), 16'h0);
        tick();
        chk("to_req_idle", 16'(a_req_op), 16'h0);
        chk("to_resp_valid", 16'(a_cpu_resp_valid), 16'h1);
        chk("to_err", 16'(a_cpu_resp_err), 16'h1);
        chk("to_rdata", a_cpu_resp_rdata, 16'hFFFF);
        a_resp_valid = 1'b1; a_resp_rdata = 16'h00EE;
        tick();
        a_resp_valid = 1'b0;
        tick();
        chk("to_stray_ignored", 16'(a_cpu_resp_valid), 16'h0);
        chk("to_stray_ready", 16'(a_cpu_req_ready), 16'h1);

        // Response arriving exactly at the limit wins.
        a_request(2'd1, 1'b0, 16'h2000, 16'h0);
        tick();
        a_cpu_req_valid = 1'b0;
        tick(); tick(); tick();
        a_resp_valid = 1'b1; a_resp_rdata = 16'h0042;
        tick();
        a_resp_valid = 1'b0;
        chk("lim_resp_valid", 16'(a_cpu_resp_valid), 16'h1);
        chk("lim_err", 16'(a_cpu_resp_err), 16'h0);
        chk("lim_rdata", a_cpu_resp_rdata, 16'h0042);
        tick();
`else
        // Without the timeout the master waits indefinitely.
        a_request(2'd1, 1'b0, 16'h1234, 16'h0);
        tick();
        a_cpu_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("nto_still_busy", 16'(a_req_op), 16'h1);
        chk("nto_no_resp", 16'(a_cpu_resp_valid), 16'h0);
        chk("nto_err", 16'(a_cpu_resp_err), 16'h0);
        a_resp_valid = 1'b1; a_resp_rdata = 16'h0099;
        tick();
        a_resp_valid = 1'b0;
        chk("nto_rdata", a_cpu_resp_rdata, 16'h0099);
        tick();
`endif

        // Reset while in the HI phase of a split word read.
        a_request(2'd1, 1'b1, 16'h3000, 16'h0);
        tick();
        a_cpu_req_valid = 1'b0;
        a_resp_valid = 1'b1; a_resp_rdata = 16'h0011;
        tick();
        chk("rm_in_hi_addr", a_req_addr, 16'h3001);
        a_resp_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_req_idle", 16'(a_req_op), 16'h0);
        chk("rm_ready", 16'(a_cpu_req_ready), 16'h1);
        chk("rm_no_resp", 16'(a_cpu_resp_valid), 16'h0);
        a_resp_valid = 1'b1; a_resp_rdata = 16'h0022;
        tick();
        a_resp_valid = 1'b0;
        chk("rm_late_no_resp", 16'(a_cpu_resp_valid), 16'h0);
        chk("rm_late_req_idle", 16'(a_req_op), 16'h0);
        a_request(2'd1, 1'b0, 16'h0042, 16'h0);
        tick();
        a_cpu_req_valid = 1'b0;
        chk("rm_new_addr", a_req_addr, 16'h0042);
        a_resp_valid = 1'b1; a_resp_rdata = 16'h9977;
        tick();
        a_resp_valid = 1'b0;
        chk("rm_new_resp_valid", 16'(a_cpu_resp_valid), 16'h1);
        chk("rm_new_rdata", a_cpu_resp_rdata, 16'h0077);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
